// File: rtl/spike_event_decoder.sv
// Consumer-side decoder for a convolution layer's output FIFO: pops packed
// {timestep, x, y, spikes} words and serializes them into per-channel spike events.
module spike_event_decoder #(
    parameter int  COORD_BITS = 8,
    parameter int  CHANNELS   = 2,
    localparam int DATA_WIDTH = 2 * (COORD_BITS - 1) + CHANNELS + 1,
    localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_read_o,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [COORD_BITS-2:0] evt_x_o,
    output logic [COORD_BITS-2:0] evt_y_o,
    output logic [CH_BITS-1:0]    evt_ch_o,
    output logic                  evt_timestep_o,
    output logic                  busy_o,
    output logic [15:0]           timestep_count_o
);

    localparam int XY_BITS = COORD_BITS - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    localparam logic [CHANNELS-1:0] ONE_MASK = CHANNELS'(1'b1);

    function automatic logic [CH_BITS-1:0] lowest_set(input logic [CHANNELS-1:0] m);
        logic [CH_BITS-1:0] idx;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = CH_BITS'(i);
            end
        end
        return idx;
    endfunction

    logic [1:0]          state_q,  state_d;
    logic [XY_BITS-1:0]  x_q,      x_d;
    logic [XY_BITS-1:0]  y_q,      y_d;
    logic [CHANNELS-1:0] mask_q,   mask_d;
    logic                ts_q,     ts_d;
    logic                valid_q,  valid_d;
    logic [CH_BITS-1:0]  ch_q,     ch_d;
    logic                evt_ts_q, evt_ts_d;
    logic [15:0]         count_q,  count_d;

    logic                word_ts_s;
    logic [XY_BITS-1:0]  word_x_s;
    logic [XY_BITS-1:0]  word_y_s;
    logic [CHANNELS-1:0] word_mask_s;

    assign word_ts_s   = fifo_data_i[DATA_WIDTH-1];
    assign word_x_s    = fifo_data_i[DATA_WIDTH-2 -: XY_BITS];
    assign word_y_s    = fifo_data_i[CHANNELS +: XY_BITS];
    assign word_mask_s = fifo_data_i[CHANNELS-1:0];

    // Next-state and next-event computation; the event registers always hold the event on offer.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        mask_d   = mask_q;
        ts_d     = ts_q;
        valid_d  = valid_q;
        ch_d     = ch_q;
        evt_ts_d = evt_ts_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                x_d    = word_x_s;
                y_d    = word_y_s;
                mask_d = word_mask_s;
                ts_d   = word_ts_s;
                if ((word_mask_s != '0) || word_ts_s) begin
                    state_d  = ST_EMIT;
                    valid_d  = 1'b1;
                    ch_d     = lowest_set(word_mask_s);
                    evt_ts_d = (word_mask_s == '0);
                end else begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b0;
                    ch_d     = '0;
                    evt_ts_d = 1'b0;
                end
            end
            ST_EMIT: begin
                if (valid_q && evt_ready_i) begin
                    if (evt_ts_q) begin
                        ts_d    = 1'b0;
                        count_d = count_q + 16'd1;
                    end else begin
                        mask_d = mask_q & ~(ONE_MASK << ch_q);
                    end
                    // Spikes drain first, so the marker only surfaces once the mask is empty.
                    if (mask_d != '0) begin
                        valid_d  = 1'b1;
                        ch_d     = lowest_set(mask_d);
                        evt_ts_d = 1'b0;
                    end else if (ts_d) begin
                        valid_d  = 1'b1;
                        ch_d     = '0;
                        evt_ts_d = 1'b1;
                    end else begin
                        valid_d  = 1'b0;
                        ch_d     = '0;
                        evt_ts_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b0;
                ch_d     = '0;
                evt_ts_d = 1'b0;
            end
        endcase
    end

    // State and event registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            mask_q   <= '0;
            ts_q     <= 1'b0;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            evt_ts_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mask_q   <= mask_d;
            ts_q     <= ts_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            evt_ts_q <= evt_ts_d;
            count_q  <= count_d;
        end
    end

    // The pop strobe must fall in the IDLE cycle itself to keep the 2-cycle word overhead.
    assign fifo_read_o      = (state_q == ST_IDLE) && !fifo_empty_i && !rst;
    assign busy_o           = (state_q != ST_IDLE);
    assign evt_valid_o      = valid_q;
    assign evt_x_o          = x_q;
    assign evt_y_o          = y_q;
    assign evt_ch_o         = ch_q;
    assign evt_timestep_o   = evt_ts_q;
    assign timestep_count_o = count_q;

endmodule

// File: tb/tb_spike_event_decoder.sv
// Bench for spike_event_decoder: directed word table, stall/reset sequences and
// randomized traffic against a queue-based event model.
module tb_spike_event_decoder;

    logic        clk;
    logic        rst;
    logic        fifo_empty_i;
    logic [16:0] fifo_data_i;
    logic        fifo_read_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [6:0]  evt_x_o;
    logic [6:0]  evt_y_o;
    logic [0:0]  evt_ch_o;
    logic        evt_timestep_o;
    logic        busy_o;
    logic [15:0] timestep_count_o;
    logic [15:0] dut_pack;

    spike_event_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_data_i      (fifo_data_i),
        .fifo_read_o      (fifo_read_o),
        .evt_valid_o      (evt_valid_o),
        .evt_ready_i      (evt_ready_i),
        .evt_x_o          (evt_x_o),
        .evt_y_o          (evt_y_o),
        .evt_ch_o         (evt_ch_o),
        .evt_timestep_o   (evt_timestep_o),
        .busy_o           (busy_o),
        .timestep_count_o (timestep_count_o)
    );

    assign dut_pack = {evt_x_o, evt_y_o, evt_ch_o, evt_timestep_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Events packed as {x[6:0], y[6:0], ch, timestep}.
    logic [16:0] fifo_q[$];
    logic [15:0] m_evts[$];
    logic [15:0] obs_q[$];
    logic        m_fetching;
    logic [16:0] m_word;
    logic [15:0] m_count;
    int          n_reads;
    bit          rand_mode;
    bit          ready_fixed;

    typedef struct {
        logic [16:0]       word;
        int                n_evt;
        logic [2:0][15:0]  e;
        logic [15:0]       ts_inc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expand(input logic [16:0] w);
        int xv;
        int yv;
        xv = int'(w >> 9) % 128;
        yv = int'(w >> 2) % 128;
        for (int ch = 0; ch < 2; ch++) begin
            if (w[ch]) m_evts.push_back(16'((xv << 9) | (yv << 2) | (ch << 1)));
        end
        if (w[16]) m_evts.push_back(16'((xv << 9) | (yv << 2) | 1));
    endtask

    task automatic model_reset();
        m_evts.delete();
        fifo_q.delete();
        obs_q.delete();
        m_fetching = 1'b0;
        m_word     = 17'd0;
        m_count    = 16'd0;
    endtask

    // One clock: check at negedge against the model, advance model, drive next inputs.
    task automatic tick();
        logic exp_busy;
        logic exp_rd;
        logic exp_valid;
        @(negedge clk);
        exp_busy  = m_fetching || (m_evts.size() != 0);
        exp_rd    = !exp_busy && !fifo_empty_i;
        exp_valid = !m_fetching && (m_evts.size() != 0);
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("read", 32'(fifo_read_o), 32'(exp_rd));
        chk("valid", 32'(evt_valid_o), 32'(exp_valid));
        chk("ts_count", 32'(timestep_count_o), 32'(m_count));
        if (exp_valid && evt_valid_o) chk("event", 32'(dut_pack), 32'(m_evts[0]));
        if (evt_valid_o && evt_ready_i) obs_q.push_back(dut_pack);
        if (fifo_read_o) n_reads++;
        if (exp_valid && evt_ready_i) begin
            if (m_evts[0][0]) m_count = m_count + 16'd1;
            void'(m_evts.pop_front());
        end
        if (m_fetching) begin
            m_fetching = 1'b0;
            expand(m_word);
        end
        if (exp_rd && fifo_q.size() != 0) begin
            m_fetching = 1'b1;
            m_word     = fifo_q.pop_front();
        end
        @(posedge clk);
        #1;
        fifo_data_i  = exp_rd ? m_word : 17'($urandom);
        fifo_empty_i = (fifo_q.size() == 0) || (rand_mode && ($urandom_range(0, 3) == 0));
        evt_ready_i  = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    endtask

    initial begin
        logic [15:0] base;
        logic [15:0] act;

        vecs[0] = '{word: 17'h00A0F, n_evt: 2, e: {16'h0000, 16'h0A0E, 16'h0A0C}, ts_inc: 16'd0};
        vecs[1] = '{word: 17'h10000, n_evt: 1, e: {16'h0000, 16'h0000, 16'h0001}, ts_inc: 16'd1};
        vecs[2] = '{word: 17'h1FFFE, n_evt: 2, e: {16'h0000, 16'hFFFD, 16'hFFFE}, ts_inc: 16'd1};
        vecs[3] = '{word: 17'h00A0C, n_evt: 0, e: {16'h0000, 16'h0000, 16'h0000}, ts_inc: 16'd0};
        vecs[4] = '{word: 17'h00A0D, n_evt: 1, e: {16'h0000, 16'h0000, 16'h0A0C}, ts_inc: 16'd0};
        vecs[5] = '{word: 17'h1FFFF, n_evt: 3, e: {16'hFFFD, 16'hFFFE, 16'hFFFC}, ts_inc: 16'd1};

        rand_mode    = 1'b0;
        ready_fixed  = 1'b1;
        n_reads      = 0;
        model_reset();
        rst          = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 17'h1FFFF;
        evt_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read", 32'(fifo_read_o), 32'd0);
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_evt", 32'(dut_pack), 32'd0);
        chk("rst_count", 32'(timestep_count_o), 32'd0);
        fifo_empty_i = 1'b1;
        rst          = 1'b0;
        repeat (2) tick();

        // Directed word table, continuous ready.
        for (int i = 0; i < 6; i++) begin
            obs_q.delete();
            n_reads = 0;
            base    = m_count;
            fifo_q.push_back(vecs[i].word);
            fifo_empty_i = 1'b0;
            repeat (8) tick();
            chk($sformatf("tbl%0d_reads", i), 32'(n_reads), 32'd1);
            chk($sformatf("tbl%0d_nevt", i), 32'(obs_q.size()), 32'(vecs[i].n_evt));
            for (int k = 0; k < vecs[i].n_evt; k++) begin
                act = (k < obs_q.size()) ? obs_q[k] : 16'hBAD0;
                chk($sformatf("tbl%0d_evt%0d", i, k), 32'(act), 32'(vecs[i].e[k]));
            end
            chk($sformatf("tbl%0d_count", i), 32'(timestep_count_o), 32'(base + vecs[i].ts_inc));
        end

        // Backpressure: event held stable, no new pop while the word is draining.
        obs_q.delete();
        n_reads     = 0;
        ready_fixed = 1'b0;
        fifo_q.push_back(17'h00A0F);
        fifo_q.push_back(17'h10000);
        fifo_empty_i = 1'b0;
        evt_ready_i  = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", 32'(evt_valid_o), 32'd1);
            chk("stall_evt", 32'(dut_pack), 32'h0A0C);
            chk("stall_read", 32'(fifo_read_o), 32'd0);
        end
        chk("stall_reads", 32'(n_reads), 32'd1);
        ready_fixed = 1'b1;
        evt_ready_i = 1'b1;
        repeat (10) tick();
        chk("stall_nevt", 32'(obs_q.size()), 32'd3);
        chk("stall_reads2", 32'(n_reads), 32'd2);

        // Reset in the middle of EMIT, after ch0 has been accepted.
        obs_q.delete();
        fifo_q.push_back(17'h00A0F);
        fifo_empty_i = 1'b0;
        repeat (3) tick();
        chk("pre_rst_evt", 32'(dut_pack), 32'h0A0E);
        chk("pre_rst_valid", 32'(evt_valid_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(evt_valid_o), 32'd0);
        chk("mid_rst_evt", 32'(dut_pack), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_read", 32'(fifo_read_o), 32'd0);
        chk("mid_rst_count", 32'(timestep_count_o), 32'd0);
        model_reset();
        fifo_empty_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_nevt", 32'(obs_q.size()), 32'd0);

        // Randomized traffic: random words, empty gaps, random ready.
        rand_mode = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 4) == 0) fifo_q.push_back(17'($urandom) & 17'h1FFFC);
                else fifo_q.push_back(17'($urandom));
            end
            tick();
        end
        rand_mode   = 1'b0;
        ready_fixed = 1'b1;
        evt_ready_i = 1'b1;
        repeat (40) tick();
        chk("drain_idle", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_event_decoder.md
Name: spike_event_decoder

Overview:
- Reader/decoder on the consumer side of a convolution layer's output FIFO.
- Pops packed output vectors of the form {timestep, x, y, spikes}, then serializes every set spike bit into one (x, y, channel) event on a valid/ready stream toward the next layer.
- A set timestep bit produces a trailing timestep-marker event after that word's spike events.

Parameters:
- COORD_BITS, 8, base coordinate width; x/y fields are COORD_BITS-1 bits wide.
- CHANNELS, 2, spike-vector width (number of output channels).
- DATA_WIDTH, 2*(COORD_BITS-1)+CHANNELS+1 (17), FIFO word width; derived, not overridden.
- CH_BITS, max(1,$clog2(CHANNELS)), channel index width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  1  output FIFO empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO read data; valid one cycle after fifo_read_o.
- fifo_read_o  out  1  FIFO pop strobe, single-cycle pulse.
- evt_valid_o  out  1  event valid.
- evt_ready_i  in  1  downstream accepts event.
- evt_x_o  out  COORD_BITS-1  event x.
- evt_y_o  out  COORD_BITS-1  event y.
- evt_ch_o  out  CH_BITS  spiking channel index (0 for markers).
- evt_timestep_o  out  1  1 = timestep-marker event, not a spike.
- busy_o  out  1  high in any state other than IDLE.
- timestep_count_o  out  16  number of markers accepted downstream; wraps 0xFFFF->0.

Behaviour:
- Word layout: bit DATA_WIDTH-1 = timestep; x = [DATA_WIDTH-2 : CHANNELS+COORD_BITS-1]; y = [CHANNELS+COORD_BITS-2 : CHANNELS]; spikes = [CHANNELS-1:0], bit ch = channel ch.
- Reset (asynchronous, takes effect immediately):
  - fifo_read_o, evt_valid_o, evt_x_o, evt_y_o, evt_ch_o, evt_timestep_o, busy_o = 0.
  - timestep_count_o = 0.
  - Internal word, mask and ts_pending registers cleared; FSM -> IDLE.
  - A word latched or in flight at reset is discarded.
- FSM states: IDLE, FETCH, EMIT.
  - IDLE:
    - If fifo_empty_i == 0: assert fifo_read_o for exactly this cycle, go to FETCH.
    - Otherwise stay in IDLE.
  - FETCH:
    - fifo_data_i is valid this cycle; latch x, y, spike mask, and ts_pending = timestep bit.
    - If mask != 0 or timestep == 1: go to EMIT.
    - Else discard the word (no event) and go to IDLE.
    - fifo_read_o = 0.
  - EMIT:
    - evt_valid_o = 1; evt_x_o/evt_y_o = latched word fields.
    - If mask != 0: evt_ch_o = index of lowest set bit, evt_timestep_o = 0.
    - Else (marker): evt_ch_o = 0, evt_timestep_o = 1.
    - On evt_valid_o && evt_ready_i:
      - Spike event: clear the emitted mask bit.
      - Marker event: clear ts_pending and increment timestep_count_o.
    - When the accepted event was the last one (mask becomes 0 and ts_pending is 0): go to IDLE.
- Handshake rules:
  - evt_valid_o never depends combinationally on evt_ready_i.
  - While evt_valid_o=1 and evt_ready_i=0, all evt_* outputs hold stable.
  - Event outputs are registered.
- Ordering:
  - Spike events are emitted in ascending channel order.
  - A word's marker is always emitted after all of that word's spike events.
  - No FIFO read is issued while in FETCH or EMIT; at most one word is in flight.
- Latency and throughput:
  - fifo_read_o to first evt_valid_o: 2 cycles.
  - One event per cycle under continuous ready.
  - Per-word overhead: 2 cycles (IDLE, FETCH).
- Boundary conditions:
  - fifo_empty_i rising while in FETCH or EMIT has no effect on the current word.
  - fifo_data_i is ignored outside FETCH.
  - A word with all spikes set and timestep=1 emits CHANNELS+1 events.
  - timestep_count_o increments only on marker acceptance and wraps silently.

Test Plan:
1. Empty=0 with word 0x00A0F (ts=0, x=5, y=3, spikes=2'b11), ready=1 -> fifo_read_o pulses once; events (5,3,ch0,ts0) then (5,3,ch1,ts0) on consecutive cycles; return to IDLE; timestep_count_o stays 0.
2. Word 0x10000 (ts=1, x=0, y=0, spikes=0) -> single event evt_timestep_o=1, ch=0, x=y=0; timestep_count_o 0->1.
3. Word 0x1FFFE (ts=1, x=127, y=127, spikes=2'b10) -> (127,127,ch1,ts0), then marker (127,127,ch0,ts1); timestep_count_o increments by 1.
4. Word 0x00A0F with ready=0 for 3 cycles after evt_valid_o rises -> ch0 event held stable for all 3 cycles; no fifo_read_o pulse until both events are accepted.
5. Word 0x00A0C (spikes=0, ts=0) followed by 0x00A0D -> first word yields no event; second yields only (5,3,ch0); exactly two fifo_read_o pulses.
6. Assert rst mid-EMIT of word 0x00A0F, after ch0 accepted -> all outputs 0 immediately; after release with fifo_empty_i=1, no events and busy_o=0; ch1 event is never emitted.
